mcif_wr_arb: RTL and testbench
==============================

MCIF_WR_ARB -- requirements
Module: mcif_wr_arb

Interface
REQ-001 The block SHALL have parameter PD_W, default 2+`log2AXI_BURST_LEN+32+`MAX_DAT_DW*`Tout, giving the MCIF write request payload width.
REQ-002 The block SHALL have parameter L, default `log2AXI_BURST_LEN, giving the cmd_length field width.
REQ-003 The block SHALL have parameter RSP_DEPTH, default 4, giving the nonposted owner-FIFO depth (power of 2).
REQ-004 Port: clk  input  1  clock; all logic on posedge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: r0_req_vld / r1_req_vld  input  1  requester 0/1 write request valid.
REQ-007 Port: r0_req_pd / r1_req_pd  input  PD_W  requester 0/1 payload.
REQ-008 Port: r0_req_rdy / r1_req_rdy  output  1  requester 0/1 ready.
REQ-009 Port: r0_rsp_complete / r1_rsp_complete  output  1  routed completion pulse to requester 0/1.
REQ-010 Port: mcif_wr_req_vld  output  1  merged request valid to MCIF.
REQ-011 Port: mcif_wr_req_pd  output  PD_W  merged payload to MCIF.
REQ-012 Port: mcif_wr_req_rdy  input  1  MCIF ready.
REQ-013 Port: mcif_wr_rsp_complete  input  1  MCIF completion pulse.
REQ-014 Port: rsp_err  output  1  sticky error: completion arrived with owner FIFO empty.
REQ-015 Port: r0_burst_cnt / r1_burst_cnt  output  32  accepted-burst counters (see Configuration).

Function
REQ-016 The payload decode SHALL be: pd[PD_W-1]=1 marks a command beat; cmd_length = pd[32+L-1:32]; nonposted = pd[32+L].
REQ-017 The FSM SHALL have states IDLE and BURST.
REQ-018 In IDLE, the eligible requesters SHALL be those with vld=1, pd[PD_W-1]=1, and, if nonposted=1, owner FIFO not full.
REQ-019 In IDLE, the selected requester SHALL be the eligible one with round-robin priority; pointer rr=0 favours r0, rr=1 favours r1; a sole eligible requester wins regardless of rr.
REQ-020 Path SHALL be combinational, zero latency: mcif_wr_req_vld = selected vld, mcif_wr_req_pd = selected pd, selected rdy = mcif_wr_req_rdy, non-selected rdy = 0.
REQ-021 With no eligible requester in IDLE, mcif_wr_req_vld SHALL be 0, pd SHALL be 0 and both rdy SHALL be 0; data beats (MSB=0) presented in IDLE SHALL be stalled, not dropped.
REQ-022 On a command handshake (vld&rdy) in IDLE, the block SHALL latch owner, load beat_cnt=cmd_length and go to BURST next cycle.
REQ-023 In the same handshake cycle, if nonposted=1 the owner ID SHALL be pushed to the owner FIFO.
REQ-024 In BURST, only the owner SHALL be routed (any MSB value passes); the other requester's rdy SHALL be 0.
REQ-025 In BURST, each accepted beat SHALL decrement beat_cnt; the beat accepted with beat_cnt==0 SHALL return FSM to IDLE and set rr = ~owner; a burst thus carries cmd_length+1 data beats.
REQ-026 Bursts SHALL be atomic: no interleaving of the other requester between command and last data beat.
REQ-027 Each cycle with mcif_wr_rsp_complete=1 SHALL pop the FIFO head and drive a 1-cycle pulse, combinationally in that cycle, on r<head>_rsp_complete.
REQ-028 A push and a pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-029 A completion with FIFO empty SHALL produce no pulse and SHALL set rsp_err until reset.
REQ-030 mcif_wr_req_rdy low SHALL hold all state; vld and pd SHALL remain as presented by the owner.

Reset
REQ-031 On rst_n low, asynchronously: FSM=IDLE, rr=0, beat_cnt=0, owner=0, FIFO empty, rsp_err=0, counters=0.
REQ-032 Reset mid-burst SHALL abandon the burst; afterwards all rdy and mcif_wr_req_vld SHALL follow the IDLE rules.

Configuration
REQ-033 With MCIF_WR_ARB_STAT_EN defined, rN_burst_cnt SHALL increment (wrapping at 2^32) on each command handshake from requester N.
REQ-034 With MCIF_WR_ARB_STAT_EN undefined, counter logic SHALL be absent and rN_burst_cnt SHALL be constant 0.

Verification
REQ-035 Scenario: r0 alone sends cmd with cmd_length=3, then 4 data beats, rdy=1 -> 5 MCIF beats in 5 cycles, FSM back to IDLE, rr=1.
REQ-036 Scenario: both send cmd in the same cycle after reset -> r0 granted first; r1 granted on the cycle after r0's last beat; no interleave.
REQ-037 Scenario: mcif_wr_req_rdy toggles 1,0,1,0 during a cmd_length=7 burst -> exactly 8 data beats passed, pd stable while stalled.
REQ-038 Scenario: nonposted cmds r1,r0,r1 then 3 completions -> pulses r1,r0,r1 in order; a 4th completion sets rsp_err=1.
REQ-039 Scenario: RSP_DEPTH=4 with 4 nonposted pending and r0 nonposted cmd -> r0 rdy=0 until a completion; a posted r1 cmd is still granted.
REQ-040 Scenario: rst_n asserted after 2 of 4 data beats -> all rdy=0 and vld=0 while in reset; FIFO empty and counters 0 after reset.

Source files
------------

// File: rtl/mcif_wr_arb.sv
// Two-requester MCIF write arbiter: round-robin command grant, atomic bursts, nonposted completion routing.
// Optional per-requester burst counters are built when MCIF_WR_ARB_STAT_EN is defined.
`ifndef log2AXI_BURST_LEN
`define log2AXI_BURST_LEN 3
`endif
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 64
`endif
`ifndef Tout
`define Tout 1
`endif

module mcif_wr_arb #(
    parameter int unsigned PD_W      = 2 + `log2AXI_BURST_LEN + 32 + `MAX_DAT_DW * `Tout,
    parameter int unsigned L         = `log2AXI_BURST_LEN,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r0_req_vld,
    input  logic [PD_W-1:0] r0_req_pd,
    output logic            r0_req_rdy,
    input  logic            r1_req_vld,
    input  logic [PD_W-1:0] r1_req_pd,
    output logic            r1_req_rdy,
    output logic            r0_rsp_complete,
    output logic            r1_rsp_complete,
    output logic            mcif_wr_req_vld,
    output logic [PD_W-1:0] mcif_wr_req_pd,
    input  logic            mcif_wr_req_rdy,
    input  logic            mcif_wr_rsp_complete,
    output logic            rsp_err,
    output logic [31:0]     r0_burst_cnt,
    output logic [31:0]     r1_burst_cnt
);

    localparam int unsigned AW = $clog2(RSP_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic [L-1:0]    beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            fifo_q [RSP_DEPTH];
    logic            rsp_err_q;

    logic            sel, gnt, hs, cmd_hs, push, pop;
    logic [PD_W-1:0] sel_pd;
    logic            fifo_empty, fifo_full, fifo_head;
    logic            r0_elig, r1_elig;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_q[rd_ptr_q[AW-1:0]];

    // A nonposted command may only start if its completion owner can be recorded.
    assign r0_elig = r0_req_vld && r0_req_pd[PD_W-1] && (!r0_req_pd[32+L] || !fifo_full);
    assign r1_elig = r1_req_vld && r1_req_pd[PD_W-1] && (!r1_req_pd[32+L] || !fifo_full);

    assign pop             = mcif_wr_rsp_complete && !fifo_empty;
    assign r0_rsp_complete = pop && !fifo_head;
    assign r1_rsp_complete = pop && fifo_head;
    assign rsp_err         = rsp_err_q;

    // Grant selection, zero-latency routing and next-state.
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        owner_d         = owner_q;
        beat_cnt_d      = beat_cnt_q;
        sel             = 1'b0;
        gnt             = 1'b0;
        push            = 1'b0;
        cmd_hs          = 1'b0;
        sel_pd          = '0;
        mcif_wr_req_vld = 1'b0;
        mcif_wr_req_pd  = '0;
        r0_req_rdy      = 1'b0;
        r1_req_rdy      = 1'b0;

        case (state_q)
            IDLE: begin
                if (r0_elig && r1_elig) begin
                    gnt = 1'b1;
                    sel = rr_q;
                end else if (r0_elig) begin
                    gnt = 1'b1;
                    sel = 1'b0;
                end else if (r1_elig) begin
                    gnt = 1'b1;
                    sel = 1'b1;
                end
            end
            BURST: begin
                gnt = 1'b1;
                sel = owner_q;
            end
            default: ;
        endcase

        if (gnt) begin
            sel_pd          = sel ? r1_req_pd : r0_req_pd;
            mcif_wr_req_vld = sel ? r1_req_vld : r0_req_vld;
            mcif_wr_req_pd  = sel_pd;
            r0_req_rdy      = !sel && mcif_wr_req_rdy;
            r1_req_rdy      = sel && mcif_wr_req_rdy;
        end

        hs = mcif_wr_req_vld && mcif_wr_req_rdy;

        if (hs) begin
            if (state_q == IDLE) begin
                cmd_hs     = 1'b1;
                state_d    = BURST;
                owner_d    = sel;
                beat_cnt_d = sel_pd[32+L-1:32];
                push       = sel_pd[32+L];
            end else if (beat_cnt_q == '0) begin
                state_d = IDLE;
                rr_d    = !owner_q;
            end else begin
                beat_cnt_d = beat_cnt_q - L'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            beat_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rsp_err_q  <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q[AW-1:0]] <= owner_d;
                wr_ptr_q                 <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (mcif_wr_rsp_complete && fifo_empty) rsp_err_q <= 1'b1;
        end
    end

`ifdef MCIF_WR_ARB_STAT_EN
    logic [31:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 32'd0;
            cnt1_q <= 32'd0;
        end else if (cmd_hs) begin
            if (sel) cnt1_q <= cnt1_q + 32'd1;
            else     cnt0_q <= cnt0_q + 32'd1;
        end
    end

    assign r0_burst_cnt = cnt0_q;
    assign r1_burst_cnt = cnt1_q;
`else
    assign r0_burst_cnt = 32'd0;
    assign r1_burst_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mcif_wr_arb.sv
// Bench for mcif_wr_arb: IDLE arbitration vector table plus scoreboarded burst/completion sequences.
module tb_mcif_wr_arb;

    localparam int unsigned PD_W  = 101;
    localparam int unsigned L     = 3;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            rst_n;
    logic            vld [2];
    logic [PD_W-1:0] pd  [2];
    logic            mrdy, mcmp;
    logic            r0_rdy, r1_rdy, r0_cmp, r1_cmp, m_vld, rsp_err;
    logic [PD_W-1:0] m_pd;
    logic [31:0]     cnt0, cnt1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_cmd [2];

    logic [PD_W-1:0] exp_q [$];
    int              exp_rsp [$];
    int              hs_cyc [$];
    bit              mon_en  = 0;
    bit              hold_en = 0;
    logic            prev_stall = 0;
    logic [PD_W-1:0] prev_pd    = '0;
    bit              done;

    mcif_wr_arb #(.PD_W(PD_W), .L(L), .RSP_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r0_req_vld          (vld[0]),
        .r0_req_pd           (pd[0]),
        .r0_req_rdy          (r0_rdy),
        .r1_req_vld          (vld[1]),
        .r1_req_pd           (pd[1]),
        .r1_req_rdy          (r1_rdy),
        .r0_rsp_complete     (r0_cmp),
        .r1_rsp_complete     (r1_cmp),
        .mcif_wr_req_vld     (m_vld),
        .mcif_wr_req_pd      (m_pd),
        .mcif_wr_req_rdy     (mrdy),
        .mcif_wr_rsp_complete(mcmp),
        .rsp_err             (rsp_err),
        .r0_burst_cnt        (cnt0),
        .r1_burst_cnt        (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PD_W-1:0] mk_pd(input bit cmd, input bit np, input int len, input logic [31:0] tag);
        logic [PD_W-1:0] p;
        p               = '0;
        p[PD_W-1]       = cmd;
        p[32+L]         = np;
        p[32+L-1:32]    = L'(len);
        p[31:0]         = tag;
        return p;
    endfunction

    function automatic logic [PD_W-1:0] beat_pd(input int id, input bit np, input int len, input int bno, input int b);
        return mk_pd(b == 0, (b == 0) && np, (b == 0) ? len : 0, 32'(id * 65536 + bno * 256 + b));
    endfunction

    function automatic void expect_burst(input int id, input bit np, input int len, input int bno);
        for (int b = 0; b <= len + 1; b++) exp_q.push_back(beat_pd(id, np, len, bno, b));
    endfunction

    task automatic check_cnt(input string name);
`ifdef MCIF_WR_ARB_STAT_EN
        check({name, "_cnt0"}, 128'(cnt0), 128'(n_cmd[0]));
        check({name, "_cnt1"}, 128'(cnt1), 128'(n_cmd[1]));
`else
        check({name, "_cnt0"}, 128'(cnt0), 128'(0));
        check({name, "_cnt1"}, 128'(cnt1), 128'(0));
`endif
    endtask

    // Present one beat from requester id and wait (bounded) for its handshake.
    task automatic drive_beat(input int id, input logic [PD_W-1:0] p, output bit ok);
        int t;
        ok      = 1'b0;
        t       = 0;
        vld[id] = 1'b1;
        pd[id]  = p;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = (id == 0) ? r0_rdy : r1_rdy;
            t++;
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no rdy on r%0d expected rdy within 200 cycles", id);
            vld[id] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_burst(input int id, input bit np, input int len, input int bno);
        bit ok;
        for (int b = 0; b <= len + 1; b++) begin
            drive_beat(id, beat_pd(id, np, len, bno, b), ok);
            if (!ok) return;
            if (b == 0) n_cmd[id]++;
        end
        vld[id] = 1'b0;
    endtask

    task automatic complete_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            mcmp = 1'b1;
            @(posedge clk);
            #1;
        end
        mcmp = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        mcmp   = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        exp_rsp.delete();
        n_cmd[0] = 0;
        n_cmd[1] = 0;
        #1 rst_n = 1'b1;
    endtask

    // Scoreboard: accepted MCIF beats and routed completions.
    always @(negedge clk) begin
        if (mon_en && rst_n && m_vld && mrdy) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got %0h expected no beat", m_pd);
            end else begin
                check("beat_pd", 128'(m_pd), 128'(exp_q.pop_front()));
            end
        end
        if (hold_en && prev_stall) begin
            check("stall_vld", 128'(m_vld), 128'(1));
            check("stall_pd", 128'(m_pd), 128'(prev_pd));
        end
        prev_stall <= m_vld && !mrdy;
        prev_pd    <= m_pd;
        if (rst_n && mcmp) begin
            if (exp_rsp.size() > 0) begin
                int e;
                e = exp_rsp.pop_front();
                check("rsp_r0", 128'(r0_cmp), 128'(e == 0));
                check("rsp_r1", 128'(r1_cmp), 128'(e == 1));
            end else begin
                check("rsp_none_r0", 128'(r0_cmp), 128'(0));
                check("rsp_none_r1", 128'(r1_cmp), 128'(0));
            end
        end
    end

    typedef struct {
        bit v0, c0, n0, v1, c1, n1, mr;
        bit ev, es, er0, er1;
    } vec_t;

    initial begin
        vec_t tbl [9];
        bit   ok;
        logic [PD_W-1:0] exp_pd;

        tbl[0] = '{0,0,0, 0,0,0, 1,  0,0,0,0};
        tbl[1] = '{1,0,0, 0,0,0, 1,  0,0,0,0};
        tbl[2] = '{1,1,0, 0,0,0, 1,  1,0,1,0};
        tbl[3] = '{0,0,0, 1,1,0, 1,  1,1,0,1};
        tbl[4] = '{1,1,0, 1,1,0, 1,  1,0,1,0};
        tbl[5] = '{1,1,0, 1,1,0, 0,  1,0,0,0};
        tbl[6] = '{1,0,0, 1,1,1, 1,  1,1,0,1};
        tbl[7] = '{1,1,1, 1,0,0, 1,  1,0,1,0};
        tbl[8] = '{0,1,0, 1,0,0, 1,  0,0,0,0};

        rst_n = 1'b0; mrdy = 1'b0; mcmp = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0; pd[0] = '0; pd[1] = '0;
        n_cmd[0] = 0; n_cmd[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 128'(m_vld), 128'(0));
        check("rst_pd", 128'(m_pd), 128'(0));
        check("rst_rdy0", 128'(r0_rdy), 128'(0));
        check("rst_rdy1", 128'(r1_rdy), 128'(0));
        check("rst_err", 128'(rsp_err), 128'(0));
        check_cnt("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // IDLE arbitration table, rr=0, FIFO empty; inputs withdrawn before each edge.
        for (int i = 0; i < 9; i++) begin
            vld[0] = tbl[i].v0;
            pd[0]  = mk_pd(tbl[i].c0, tbl[i].n0, i, 32'(32'h100 + i));
            vld[1] = tbl[i].v1;
            pd[1]  = mk_pd(tbl[i].c1, tbl[i].n1, i, 32'(32'h200 + i));
            mrdy   = tbl[i].mr;
            exp_pd = tbl[i].ev ? (tbl[i].es ? pd[1] : pd[0]) : '0;
            @(negedge clk);
            check($sformatf("tbl%0d_vld", i), 128'(m_vld), 128'(tbl[i].ev));
            check($sformatf("tbl%0d_pd", i), 128'(m_pd), 128'(exp_pd));
            check($sformatf("tbl%0d_rdy0", i), 128'(r0_rdy), 128'(tbl[i].er0));
            check($sformatf("tbl%0d_rdy1", i), 128'(r1_rdy), 128'(tbl[i].er1));
            vld[0] = 1'b0; vld[1] = 1'b0; mrdy = 1'b0;
            @(posedge clk);
            #1;
        end

        // r0 alone, cmd_length=3: 5 beats in 5 consecutive cycles, then rr favours r1.
        mon_en = 1'b1;
        mrdy   = 1'b1;
        hs_cyc.delete();
        expect_burst(0, 0, 3, 1);
        send_burst(0, 0, 3, 1);
        check("s35_beats", 128'(hs_cyc.size()), 128'(5));
        if (hs_cyc.size() == 5) check("s35_span", 128'(hs_cyc[4] - hs_cyc[0]), 128'(4));
        check("s35_left", 128'(exp_q.size()), 128'(0));
        check_cnt("s35");
        mrdy   = 1'b0;
        vld[0] = 1'b1; pd[0] = mk_pd(1, 0, 0, 32'h0abc);
        vld[1] = 1'b1; pd[1] = mk_pd(1, 0, 0, 32'h1abc);
        @(negedge clk);
        check("s35_rr1_pd", 128'(m_pd), 128'(pd[1]));
        vld[0] = 1'b0; vld[1] = 1'b0;
        @(posedge clk);
        #1;

        // Simultaneous commands after reset: r0 first, r1 right after r0's last beat.
        do_reset();
        mrdy = 1'b1;
        hs_cyc.delete();
        expect_burst(0, 0, 2, 2);
        expect_burst(1, 0, 1, 3);
        fork
            send_burst(0, 0, 2, 2);
            send_burst(1, 0, 1, 3);
        join
        check("s36_beats", 128'(hs_cyc.size()), 128'(7));
        if (hs_cyc.size() == 7) check("s36_r1_start", 128'(hs_cyc[4]), 128'(hs_cyc[3] + 1));
        check("s36_left", 128'(exp_q.size()), 128'(0));
        check_cnt("s36");

        // Toggling MCIF ready across a cmd_length=7 burst.
        hs_cyc.delete();
        expect_burst(0, 0, 7, 4);
        done    = 1'b0;
        mrdy    = 1'b0;
        hold_en = 1'b1;
        fork
            begin
                send_burst(0, 0, 7, 4);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    mrdy = !mrdy;
                    @(posedge clk);
                    #1;
                end
            end
        join
        hold_en = 1'b0;
        mrdy    = 1'b1;
        check("s37_beats", 128'(hs_cyc.size()), 128'(9));
        check("s37_left", 128'(exp_q.size()), 128'(0));

        // Nonposted r1,r0,r1 then completions routed in order; a surplus one raises rsp_err.
        expect_burst(1, 1, 0, 5); exp_rsp.push_back(1);
        expect_burst(0, 1, 0, 6); exp_rsp.push_back(0);
        expect_burst(1, 1, 0, 7); exp_rsp.push_back(1);
        send_burst(1, 1, 0, 5);
        send_burst(0, 1, 0, 6);
        send_burst(1, 1, 0, 7);
        check("s38_err_before", 128'(rsp_err), 128'(0));
        complete_pulses(3);
        check("s38_rsp_left", 128'(exp_rsp.size()), 128'(0));
        check("s38_err_mid", 128'(rsp_err), 128'(0));
        complete_pulses(1);
        check("s38_err_after", 128'(rsp_err), 128'(1));
        check_cnt("s38");

        // Owner FIFO full: r0 nonposted blocked, posted r1 still granted.
        do_reset();
        check("s39_err_cleared", 128'(rsp_err), 128'(0));
        mrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_burst(0, 1, 0, 10 + i);
            exp_rsp.push_back(0);
            send_burst(0, 1, 0, 10 + i);
        end
        expect_burst(1, 0, 0, 20);
        expect_burst(0, 1, 0, 21);
        exp_rsp.push_back(0);
        fork
            send_burst(0, 1, 0, 21);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("s39_full_rdy0", 128'(r0_rdy), 128'(0));
                    check("s39_full_vld", 128'(m_vld), 128'(0));
                end
                @(posedge clk);
                #1;
                send_burst(1, 0, 0, 20);
                @(negedge clk);
                check("s39_still_blocked", 128'(r0_rdy), 128'(0));
                @(posedge clk);
                #1;
                complete_pulses(2);
            end
        join
        check("s39_left", 128'(exp_q.size()), 128'(0));
        complete_pulses(3);
        check("s39_err_drained", 128'(rsp_err), 128'(0));
        complete_pulses(1);
        check("s39_err_empty", 128'(rsp_err), 128'(1));
        check_cnt("s39");

        // Reset in the middle of a nonposted burst.
        do_reset();
        mrdy = 1'b1;
        expect_burst(0, 1, 3, 30);
        ok = 1'b1;
        for (int b = 0; b < 3 && ok; b++) drive_beat(0, beat_pd(0, 1, 3, 30, b), ok);
        vld[0] = 1'b1;
        pd[0]  = beat_pd(0, 1, 3, 30, 3);
        rst_n  = 1'b0;
        #1;
        check("s40_rst_rdy0", 128'(r0_rdy), 128'(0));
        check("s40_rst_rdy1", 128'(r1_rdy), 128'(0));
        check("s40_rst_vld", 128'(m_vld), 128'(0));
        repeat (2) @(posedge clk);
        exp_q.delete();
        exp_rsp.delete();
        n_cmd[0] = 0;
        n_cmd[1] = 0;
        #1 rst_n = 1'b1;
        #1;
        check("s40_post_vld", 128'(m_vld), 128'(0));
        check("s40_post_rdy0", 128'(r0_rdy), 128'(0));
        check("s40_post_err", 128'(rsp_err), 128'(0));
        check_cnt("s40");
        vld[0] = 1'b0;
        @(posedge clk);
        #1;
        complete_pulses(1);
        check("s40_fifo_empty", 128'(rsp_err), 128'(1));

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
